// File: rtl/lcd_spi_capture.sv
// lcd_spi_capture: passive snooper for a write-only LCD SPI bus.
// It synchronises cs/dc/sck/mosi into clk and assembles 16-bit pixel words
// (plus 8-bit command bytes when LCD_CAPTURE_CMD_EN is defined). Captured words
// are queued in a small FIFO for a valid/ready consumer. The block also
// counts accepted pixel words and flags words dropped on a full FIFO.
// Optional feature macro: LCD_CAPTURE_CMD_EN (capture command bytes).
module lcd_spi_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int W_PIXCOUNT = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lcd_cs,
    input  logic                  lcd_dc,
    input  logic                  lcd_sck,
    input  logic                  lcd_mosi,
    output logic [15:0]           out_data,
    output logic                  out_is_cmd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [W_PIXCOUNT-1:0] pixel_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);

    // Synchroniser bit order is {cs, dc, sck, mosi}; cs idles high (deselected)
    localparam logic [3:0] SYNC_RST = 4'b1000;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic [3:0]  sync_meta, sync_q;
    logic        cs_s, dc_s, sck_s, mosi_s;
    logic        sck_prev, sck_rise;

    state_t      state, state_next;
    logic        shift_active;

    logic [4:0]  bit_cnt, cnt_inc;
    logic [15:0] shift_reg, shift_in;
    logic        bit_en, word_done;
    logic        push_req, push_is_data;
    logic [15:0] push_data;

    logic [15:0]   mem_data [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push_ok, pop;

    // Two-flop synchronisers for the SPI pins, plus last sck sample for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= SYNC_RST;
            sync_q    <= SYNC_RST;
            sck_prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage samples the pre-edge value of the
            // previous one; blocking would merge both stages into a single flop.
            sync_meta <= {lcd_cs, lcd_dc, lcd_sck, lcd_mosi};
            sync_q    <= sync_meta;
            sck_prev  <= sck_s;
        end
    end

    assign {cs_s, dc_s, sck_s, mosi_s} = sync_q;
    assign sck_rise = sck_s & ~sck_prev;

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame is open while synced cs is low
    always_comb begin
        // NOTE: default first, so every path assigns state_next and no latch appears.
        state_next = state;
        case (state)
            ST_IDLE:  if (!cs_s) state_next = ST_SHIFT;
            ST_SHIFT: if (cs_s)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign shift_active = (state == ST_SHIFT) && !cs_s;
    assign shift_in     = {shift_reg[14:0], mosi_s};

`ifdef LCD_CAPTURE_CMD_EN
    logic word_cmd, push_cmd, bit_first, cur_cmd;

    // Word type locks at bit 0; a dc flip mid-word restarts the word at this bit
    always_comb begin
        bit_first = (bit_cnt == 5'd0) || (dc_s == word_cmd);
        cur_cmd   = bit_first ? ~dc_s : word_cmd;
        cnt_inc   = bit_first ? 5'd1 : bit_cnt + 5'd1;
        bit_en    = 1'b1;
        word_done = cur_cmd ? (cnt_inc == 5'd8) : (cnt_inc == 5'd16);
    end

    assign push_is_data = !push_cmd;
`else
    // Pixel data only: a dc=0 bit is not counted and abandons any partial word
    always_comb begin
        cnt_inc   = bit_cnt + 5'd1;
        bit_en    = dc_s;
        word_done = (cnt_inc == 5'd16);
    end

    assign push_is_data = 1'b1;
`endif

    // Bit assembly; a completed word is handed to the FIFO one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            push_req  <= 1'b0;
            push_data <= '0;
`ifdef LCD_CAPTURE_CMD_EN
            word_cmd  <= 1'b0;
            push_cmd  <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
            if (!shift_active) begin
                bit_cnt <= '0;
            end else if (sck_rise) begin
                if (!bit_en) begin
                    bit_cnt <= '0;
                end else begin
                    shift_reg <= shift_in;
`ifdef LCD_CAPTURE_CMD_EN
                    word_cmd  <= cur_cmd;
`endif
                    if (word_done) begin
                        bit_cnt  <= '0;
                        push_req <= 1'b1;
`ifdef LCD_CAPTURE_CMD_EN
                        push_cmd  <= cur_cmd;
                        push_data <= cur_cmd ? {8'h00, shift_in[7:0]} : shift_in;
`else
                        push_data <= shift_in;
`endif
                    end else begin
                        bit_cnt <= cnt_inc;
                    end
                end
            end
        end
    end

    assign full      = (count == FULL_LEVEL);
    assign push_ok   = push_req && !full;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // FIFO storage write port
    // NOTE: storage is deliberately not reset; only pointers and count are, and
    // the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_data[wr_ptr] <= push_data;
    end

`ifdef LCD_CAPTURE_CMD_EN
    logic mem_cmd [FIFO_DEPTH];

    // Word-type storage alongside each FIFO entry
    always_ff @(posedge clk) begin
        if (push_ok) mem_cmd[wr_ptr] <= push_cmd;
    end

    assign out_is_cmd = out_valid && mem_cmd[rd_ptr];
`else
    assign out_is_cmd = 1'b0;
`endif

    assign out_data = out_valid ? mem_data[rd_ptr] : 16'h0000;

    // FIFO pointers and occupancy; a push on full is dropped even if a pop happens
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Pixel counter and sticky overflow (a drop wins over a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok && push_is_data) pixel_count <= pixel_count + W_PIXCOUNT'(1);
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_spi_capture.sv
// tb_lcd_spi_capture: directed and randomized checks of lcd_spi_capture.
// The SPI master is driven from clk-aligned steps; a queue-based model holds
// the words the consumer should see and the expected pixel count.
module tb_lcd_spi_capture;

    localparam int FIFO_DEPTH = 4;
    localparam int W_PIXCOUNT = 24;

    logic                  clk          = 1'b0;
    logic                  rst_n        = 1'b0;
    logic                  lcd_cs       = 1'b1;
    logic                  lcd_dc       = 1'b1;
    logic                  lcd_sck      = 1'b0;
    logic                  lcd_mosi     = 1'b0;
    logic                  out_ready    = 1'b1;
    logic                  clr_overflow = 1'b0;
    logic [15:0]           out_data;
    logic                  out_is_cmd;
    logic                  out_valid;
    logic                  overflow;
    logic [W_PIXCOUNT-1:0] pixel_count;

    int vectors     = 0;
    int miscompares = 0;
    int exp_pix     = 0;
    int valid_cycles = 0;

    // Entries are {is_cmd, data}
    logic [16:0] exp_q[$];
    logic [16:0] rcv_q[$];

    lcd_spi_capture #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .W_PIXCOUNT (W_PIXCOUNT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lcd_cs       (lcd_cs),
        .lcd_dc       (lcd_dc),
        .lcd_sck      (lcd_sck),
        .lcd_mosi     (lcd_mosi),
        .out_data     (out_data),
        .out_is_cmd   (out_is_cmd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .pixel_count  (pixel_count)
    );

    always #5 clk = ~clk;

    // Consumer side: a word present at the falling edge with ready high is popped next edge
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1) begin
            valid_cycles++;
            if (out_ready) rcv_q.push_back({out_is_cmd, out_data});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},   32'(out_valid),   32'd0);
        check({tag, "_out_data"},    32'(out_data),    32'd0);
        check({tag, "_out_is_cmd"},  32'(out_is_cmd),  32'd0);
        check({tag, "_overflow"},    32'(overflow),    32'd0);
        check({tag, "_pixel_count"}, 32'(pixel_count), 32'd0);
    endtask

    // One SPI bit: data set with sck low, sampled on the rising edge four clocks later
    task automatic send_bit(input logic dc, input logic b);
        lcd_sck  = 1'b0;
        lcd_dc   = dc;
        lcd_mosi = b;
        tick(4);
        lcd_sck = 1'b1;
        tick(4);
    endtask

    task automatic send_bits(input logic dc, input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(dc, v[i]);
    endtask

    task automatic start_frame();
        lcd_sck = 1'b0;
        lcd_cs  = 1'b0;
        tick(6);
    endtask

    task automatic end_frame();
        lcd_sck = 1'b0;
        tick(4);
        lcd_cs = 1'b1;
        tick(8);
    endtask

    // Model: a full pixel word is always expected and counted
    task automatic send_data(input logic [15:0] w);
        send_bits(1'b1, w, 16);
        exp_q.push_back({1'b0, w});
        exp_pix++;
    endtask

    // Model: a command byte is expected only when command capture is built in
    task automatic send_cmd(input logic [7:0] b);
        send_bits(1'b0, {8'h00, b}, 8);
`ifdef LCD_CAPTURE_CMD_EN
        exp_q.push_back({1'b1, 8'h00, b});
`endif
    endtask

    task automatic compare_rx(input string tag);
        tick(10);
        check({tag, "_word_count"}, 32'(rcv_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), 32'(rcv_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_pixel_count"}, 32'(pixel_count), 32'(exp_pix));
        exp_q.delete();
        rcv_q.delete();
    endtask

    task automatic reset_dut();
        rst_n   = 1'b0;
        lcd_cs  = 1'b1;
        lcd_sck = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        exp_q.delete();
        rcv_q.delete();
        exp_pix = 0;
    endtask

    initial begin
        int          nw;
        int          kind;
        logic [15:0] w;
        logic [15:0] first_word;

        // Reset state
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(4);

        // Single pixel word, consumer always ready
        valid_cycles = 0;
        start_frame();
        send_data(16'hF81F);
        end_frame();
        check("f81f_valid_cycles", 32'(valid_cycles), 32'd1);
        compare_rx("f81f");

        // Command byte followed by a pixel word
        reset_dut();
        start_frame();
        send_cmd(8'h2C);
        send_data(16'h07E0);
        end_frame();
        compare_rx("cmd_data");

        // Randomized frames: data, commands, dc flips mid-word, aborted tails
        for (int f = 0; f < 8; f++) begin
            nw = $urandom_range(1, 3);
            start_frame();
            for (int k = 0; k < nw; k++) begin
                kind = $urandom_range(0, 4);
                w    = 16'($urandom);
                if (kind == 0) begin
                    send_cmd(w[7:0]);
`ifdef LCD_CAPTURE_CMD_EN
                end else if (kind == 1) begin
                    send_bits(1'b1, w, $urandom_range(1, 15));
                    send_cmd(w[15:8]);
`endif
                end else begin
                    send_data(w);
                end
            end
            if ($urandom_range(0, 2) == 0) send_bits(1'b1, 16'($urandom), $urandom_range(1, 15));
            end_frame();
        end
        compare_rx("random");

        // Frame aborted after 9 bits, then a clean word
        start_frame();
        send_bits(1'b1, 16'hAAAA, 9);
        end_frame();
        start_frame();
        send_data(16'h1234);
        end_frame();
        compare_rx("abort9");

        // Reset pulsed mid-word
        start_frame();
        send_data(16'h0F0F);
        send_bits(1'b1, 16'h5555, 10);
        rst_n   = 1'b0;
        lcd_sck = 1'b0;
        tick(1);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        exp_q.delete();
        rcv_q.delete();
        exp_pix = 0;
        tick(4);
        end_frame();
        start_frame();
        send_data(16'hABCD);
        end_frame();
        compare_rx("post_reset");

        // Overflow: stalled consumer, FIFO_DEPTH+1 words; only the first FIFO_DEPTH survive
        reset_dut();
        out_ready  = 1'b0;
        first_word = 16'h0000;
        start_frame();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            w = 16'($urandom);
            if (i == 0) first_word = w;
            if (i < FIFO_DEPTH) begin
                send_data(w);
            end else begin
                send_bits(1'b1, w, 16);
            end
        end
        tick(10);
        check("ovf_out_valid",   32'(out_valid),   32'd1);
        check("ovf_overflow",    32'(overflow),    32'd1);
        check("ovf_pixel_count", 32'(pixel_count), 32'(FIFO_DEPTH));
        check("ovf_head_stable", 32'(out_data),    32'(first_word));

        // Another dropped word with clr_overflow on exactly its push cycle
        w = 16'($urandom);
        send_bits(1'b1, w, 15);
        lcd_sck  = 1'b0;
        lcd_dc   = 1'b1;
        lcd_mosi = w[0];
        tick(4);
        lcd_sck = 1'b1;
        tick(3);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("ovf_set_beats_clear", 32'(overflow), 32'd1);
        tick(3);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        check("ovf_clear_alone", 32'(overflow), 32'd0);
        end_frame();

        out_ready = 1'b1;
        compare_rx("ovf_drain");
        check("ovf_drained_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
